// File: rtl/common_gnss_types_pkg.sv
// Shared GNSS front-end types: replay FSM states and small width helpers.
package common_gnss_types_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } replay_state_t;

  // Slot pointer width; never zero so a single-slot word still gets a 1-bit pointer.
  function automatic int ptr_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/gnss_sample_replay_if.sv
// Bus-side word stream into the sample replay block.
interface gnss_sample_replay_if #(
  parameter int IN_W = 32
) ();
  // A word transfers on a rising edge where in_valid && in_ready; the source holds
  // in_data/in_valid stable until that edge, and in_ready never depends on in_valid.
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/gnss_sample_fifo.sv
// Small word FIFO with push/pop/flush and a registered occupancy count.
module gnss_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gnss_sample_replay.sv
// Serialises buffered sample words into CHANNELS x SAMPLE_W groups, one per tick,
// LSB group first, with sticky underrun detection.
module gnss_sample_replay
  import common_gnss_types_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int SAMPLE_W = 1,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_flush,
  input  logic                           i_tick,
  input  logic                           i_clear_underrun,
  gnss_sample_replay_if.slave            s_in,
  output logic [SAMPLE_W*CHANNELS-1:0]   o_sample_out,
  output logic                           o_sample_valid,
  output logic                           o_underrun,
  output logic [31:0]                    o_sample_count,
  output replay_state_t                  o_state
);
  localparam int OUT_W = SAMPLE_W * CHANNELS;
  localparam int SLOTS = IN_W / OUT_W;
  localparam int PTR_W = ptr_width(SLOTS);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

  replay_state_t    r_state;
  replay_state_t    w_next_state;
  logic [IN_W-1:0]  r_shift;
  logic [PTR_W-1:0] r_ptr;
  logic [OUT_W-1:0] r_sample_out;
  logic             r_sample_valid;
  logic             r_underrun;
  logic [31:0]      r_sample_count;
  logic             w_pop;
  logic             w_emit;
  logic             w_underrun_evt;
  logic             w_full;
  logic             w_empty;
  logic [IN_W-1:0]  w_fifo_data;

  gnss_sample_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_in.in_valid),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_data  (s_in.in_data),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_in.in_ready  = !w_full;
  assign o_sample_out   = r_sample_out;
  assign o_sample_valid = r_sample_valid;
  assign o_underrun     = r_underrun;
  assign o_sample_count = r_sample_count;
  assign o_state        = r_state;

  always_comb begin
    w_next_state   = r_state;
    w_pop          = 1'b0;
    w_emit         = 1'b0;
    w_underrun_evt = 1'b0;
    if (!i_en) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_LOAD;
        ST_LOAD: begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_tick) begin
            w_emit = 1'b1;
            // Reload on the last slot's tick keeps back-to-back words gapless.
            if (r_ptr == LAST_SLOT) begin
              if (!w_empty) w_pop = 1'b1;
              else          w_next_state = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          // A tick on the reload cycle is still lost, hence an underrun either way.
          w_underrun_evt = i_tick;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_RUN;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_ptr          <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_underrun     <= 1'b0;
      r_sample_count <= '0;
    end else begin
      r_state        <= w_next_state;
      r_sample_valid <= w_emit;
      if (w_emit) begin
        r_sample_out   <= r_shift[OUT_W-1:0];
        r_sample_count <= r_sample_count + 32'd1;
      end
      if (w_pop) begin
        r_shift <= w_fifo_data;
        r_ptr   <= '0;
      end else if (w_emit) begin
        r_shift <= r_shift >> OUT_W;
        r_ptr   <= r_ptr + 1'b1;
      end else if (!i_en) begin
        r_ptr   <= '0;
      end
      if (w_underrun_evt)                  r_underrun <= 1'b1;
      else if (i_clear_underrun || !i_en)  r_underrun <= 1'b0;
    end
  end

endmodule
